// File: rtl/temporizador_pkg.sv
// Shared types for the countdown timer: FSM states, cursor field codes,
// and the packed two-digit BCD value used for hours, minutes and seconds.
package temporizador_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PROG,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam logic [3:0] CUR_HORA = 4'd6;
    localparam logic [3:0] CUR_MIN  = 4'd7;
    localparam logic [3:0] CUR_SEG  = 4'd8;

    // Tens digit in the upper nibble, units digit in the lower nibble.
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_pair_t;

    // Converts a binary constant (0-99) into its packed BCD form.
    function automatic bcd_pair_t to_bcd(input int unsigned v);
        bcd_pair_t r;
        r.tens = 4'((v / 10) % 10);
        r.ones = 4'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD up/down counter that wraps between 00 and MAX in both
// directions. borrow_out flags a decrement taken from 00, so callers can
// chain fields into a countdown. Simultaneous inc and dec are ignored.
module bcd_pair_counter
    import temporizador_pkg::*;
#(
    parameter int unsigned MAX = 59
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      load,
    input  bcd_pair_t load_value,
    input  logic      inc,
    input  logic      dec,
    output logic      borrow_out,
    output bcd_pair_t value
);

    localparam bcd_pair_t MAX_BCD = to_bcd(MAX);

    assign borrow_out = dec && !inc && (value == '0);

    // Value register: reset, then load, then a single-direction step.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (inc && !dec) begin
            if (value == MAX_BCD) begin
                value <= '0;
            end else if (value.ones == 4'd9) begin
                value.tens <= value.tens + 4'd1;
                value.ones <= 4'd0;
            end else begin
                value.ones <= value.ones + 4'd1;
            end
        end else if (dec && !inc) begin
            if (value == '0) begin
                value <= MAX_BCD;
            end else if (value.ones == 4'd0) begin
                value.tens <= value.tens - 4'd1;
                value.ones <= 4'd9;
            end else begin
                value.ones <= value.ones - 4'd1;
            end
        end
    end

endmodule

// File: rtl/temporizador_control.sv
// Programmable HH:MM:SS countdown timer with a five-state control FSM.
// Optional macro TEMPORIZADOR_AUTO_RELOAD_EN adds a preset register that
// is reloaded when the countdown reaches zero, keeping the timer in RUN.
module temporizador_control
    import temporizador_pkg::*;
#(
    parameter int unsigned HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       prog_on,
    input  logic [3:0] cursor,
    input  logic       inc,
    input  logic       dec,
    input  logic       start,
    input  logic       stop,
    input  logic       ack,
    output logic [7:0] timer_hora,
    output logic [7:0] timer_min,
    output logic [7:0] timer_seg,
    output logic       running,
    output logic       expired
);

    state_t    state;
    logic      edit_inc, edit_dec, run_tick, at_one, is_zero, wrap_tick;
    logic      seg_borrow, min_borrow, unused_hora_borrow;
    logic      reload;
    bcd_pair_t pre_hora, pre_min, pre_seg;

    // Edits only in PROG, and only when exactly one of inc/dec is high.
    assign edit_inc  = (state == PROG) && inc && !dec;
    assign edit_dec  = (state == PROG) && dec && !inc;
    assign run_tick  = (state == RUN) && tick_1hz;
    // Counting down by one from nonzero lands on zero only from 00:00:01.
    assign at_one    = (timer_hora == 8'h00) && (timer_min == 8'h00) && (timer_seg == 8'h01);
    assign is_zero   = (timer_hora == 8'h00) && (timer_min == 8'h00) && (timer_seg == 8'h00);
    assign wrap_tick = run_tick && at_one;

`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
    assign reload = wrap_tick;

    // Preset follows the programmed value each time PROG is left.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_hora <= '0;
            pre_min  <= '0;
            pre_seg  <= '0;
        end else if (state == PROG && !prog_on) begin
            pre_hora <= timer_hora;
            pre_min  <= timer_min;
            pre_seg  <= timer_seg;
        end
    end
`else
    assign reload   = 1'b0;
    assign pre_hora = '0;
    assign pre_min  = '0;
    assign pre_seg  = '0;
`endif

    bcd_pair_counter #(.MAX(59)) u_seg (
        .clk        (clk),
        .reset      (reset),
        .load       (reload),
        .load_value (pre_seg),
        .inc        (edit_inc && cursor == CUR_SEG),
        .dec        ((edit_dec && cursor == CUR_SEG) || run_tick),
        .borrow_out (seg_borrow),
        .value      (timer_seg)
    );

    bcd_pair_counter #(.MAX(59)) u_min (
        .clk        (clk),
        .reset      (reset),
        .load       (reload),
        .load_value (pre_min),
        .inc        (edit_inc && cursor == CUR_MIN),
        .dec        ((edit_dec && cursor == CUR_MIN) || (run_tick && seg_borrow)),
        .borrow_out (min_borrow),
        .value      (timer_min)
    );

    // Hours never borrow in RUN: zero is caught before it could underflow.
    bcd_pair_counter #(.MAX(HOUR_MAX)) u_hora (
        .clk        (clk),
        .reset      (reset),
        .load       (reload),
        .load_value (pre_hora),
        .inc        (edit_inc && cursor == CUR_HORA),
        .dec        ((edit_dec && cursor == CUR_HORA) || (run_tick && min_borrow)),
        .borrow_out (unused_hora_borrow),
        .value      (timer_hora)
    );

    // Control FSM with registered running/expired status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            case (state)
                IDLE, PAUSE: begin
                    expired <= 1'b0;
                    if (prog_on) begin
                        state <= PROG;
                    end else if (start && !is_zero) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (state == PAUSE && ack) begin
                        state <= IDLE;
                    end
                end
                PROG: begin
                    if (!prog_on) state <= IDLE;
                end
                RUN: begin
`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
                    expired <= wrap_tick;
                    if (stop) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
`else
                    if (wrap_tick) begin
                        state   <= DONE;
                        running <= 1'b0;
                        expired <= 1'b1;
                    end else if (stop) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
`endif
                end
                DONE: begin
                    if (ack) begin
                        state   <= IDLE;
                        expired <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    expired <= 1'b0;
                end
            endcase
        end
    end

endmodule
